// File: rtl/spdif_pkg.sv
// Shared S/PDIF definitions: preamble patterns (level-1 form), subframe
// geometry, preamble-kind and transmitter-phase enums.
// Optional build macro used by the transmitter: SPDIF_TX_PARITY_EN.
package spdif_pkg;

   localparam int unsigned CELLS_PER_SUBFRAME = 64;
   localparam int unsigned CELL_W             = $clog2(CELLS_PER_SUBFRAME);
   localparam int unsigned PRE_CELLS          = 8;
   localparam int unsigned DATA_BITS          = 24;
   localparam int unsigned CTL_BITS           = 4;
   localparam int unsigned CELL_DATA_FIRST    = PRE_CELLS;
   localparam int unsigned CELL_CTL_FIRST     = PRE_CELLS + 2 * DATA_BITS;

   // Preamble cell patterns as sent after a line level of 1, first cell in bit 7
   localparam logic [7:0] PRE_B = 8'b0001_0111;
   localparam logic [7:0] PRE_M = 8'b0001_1101;
   localparam logic [7:0] PRE_W = 8'b0001_1011;

   typedef enum logic [1:0] {PK_B, PK_M, PK_W} pre_kind_e;

   typedef enum logic [1:0] {ST_PRE, ST_DATA, ST_CTL} tx_state_e;

   function automatic logic [7:0] pre_pattern(input pre_kind_e kind);
      case (kind)
         PK_M:    return PRE_M;
         PK_W:    return PRE_W;
         default: return PRE_B;
      endcase
   endfunction

endpackage

// File: rtl/spdif_bmc_cell.sv
// Next-cell level generator for one biphase cell. Preamble cells follow the
// level-1 pattern expressed as transitions, so the same logic serves both
// previous-level polarities; data/control cells are plain biphase-mark.
module spdif_bmc_cell
   import spdif_pkg::*;
(
   input  logic              level_i,
   input  logic [CELL_W-1:0] cell_i,
   input  logic              bit_i,
   input  logic [7:0]        pre_i,
   output logic              level_o
);

   logic [8:0] ext;
   logic [3:0] pos;
   logic       flip;

   // A preamble cell flips whenever the level-1 pattern changes relative to
   // its predecessor (an implicit 1 sits before the first cell)
   always_comb begin
      ext  = {1'b1, pre_i};
      pos  = 4'd7 - {1'b0, cell_i[2:0]};
      flip = 1'b0;
      if (cell_i < CELL_W'(PRE_CELLS)) begin
         flip = ext[pos] ^ ext[pos + 4'd1];
      end else if (!cell_i[0]) begin
         flip = 1'b1;
      end else begin
         flip = bit_i;
      end
      level_o = level_i ^ flip;
   end

endmodule

// File: rtl/spdif_tx.sv
// S/PDIF-style biphase-mark transmitter. Pulls one 24-bit sample per
// subframe (ack_o), prefixes a B/M/W preamble and appends VUCP, and drives
// a continuous BMC stream on signal_o.
// Build macro: SPDIF_TX_PARITY_EN selects VUC=000 with even parity in P;
// otherwise VUCP is the constant 1111.
module spdif_tx
   import spdif_pkg::*;
#(
   parameter int unsigned CLK_PER_CELL     = 4,
   parameter int unsigned FRAMES_PER_BLOCK = 192
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] data_i,
   input  logic        valid_i,
   output logic        ack_o,
   output logic        lr_o,
   output logic        underrun_o,
   output logic        signal_o
);

   localparam int unsigned SF_COUNT = 2 * FRAMES_PER_BLOCK;
   localparam int unsigned DIV_W    = (CLK_PER_CELL > 1) ? $clog2(CLK_PER_CELL) : 1;
   localparam int unsigned SF_W     = (SF_COUNT > 1) ? $clog2(SF_COUNT) : 1;
   localparam int unsigned WORD_W   = DATA_BITS + CTL_BITS;

   logic [DIV_W-1:0]     div_q, div_d;
   logic [CELL_W-1:0]    cell_q, cell_d;
   logic [SF_W-1:0]      sf_q, sf_d;
   tx_state_e            state_q, state_d;
   pre_kind_e            pk_q, pk_d;
   logic [WORD_W-1:0]    shift_q, shift_d;
   logic                 sig_q, sig_d;
   logic                 ack_q, ack_d;
   logic                 lr_q, lr_d;
   logic                 und_q, und_d;

   logic                 load;
   logic                 cell_start;
   logic                 cell_last;
   logic [DATA_BITS-1:0] sample;
   logic [CTL_BITS-1:0]  ctl;
   logic [7:0]           pre_pat;
   logic                 bmc_level;

   assign pre_pat = pre_pattern(pk_q);

   spdif_bmc_cell u_bmc (
      .level_i (sig_q),
      .cell_i  (cell_q),
      .bit_i   (shift_q[WORD_W-1]),
      .pre_i   (pre_pat),
      .level_o (bmc_level)
   );

   // Next-state: cell timing, sample load, line level and phase tracking
   always_comb begin
      load       = (div_q == '0) && (cell_q == '0);
      cell_start = (div_q == DIV_W'(1));
      cell_last  = (div_q == DIV_W'(CLK_PER_CELL - 1));
      sample     = valid_i ? data_i : '0;
`ifdef SPDIF_TX_PARITY_EN
      ctl        = {3'b000, ^sample};
`else
      ctl        = '1;
`endif

      div_d   = cell_last ? '0 : div_q + DIV_W'(1);
      cell_d  = cell_last ? cell_q + CELL_W'(1) : cell_q;
      sf_d    = sf_q;
      state_d = state_q;
      pk_d    = pk_q;
      shift_d = shift_q;
      sig_d   = sig_q;
      lr_d    = lr_q;
      ack_d   = load;
      und_d   = load & ~valid_i;

      if (load) begin
         lr_d    = sf_q[0];
         pk_d    = (sf_q == '0) ? PK_B : (sf_q[0] ? PK_W : PK_M);
         shift_d = {sample, ctl};
         sf_d    = (sf_q == SF_W'(SF_COUNT - 1)) ? '0 : sf_q + SF_W'(1);
      end

      // Cells change one clock after the divider wraps, so cell k of a
      // subframe loaded at edge T0 appears at T0+1+k*CLK_PER_CELL.
      if (cell_start) begin
         sig_d = bmc_level;
         if ((state_q != ST_PRE) && cell_q[0]) begin
            shift_d = shift_q << 1;
         end
      end

      if (cell_last) begin
         if (cell_d == CELL_W'(CELL_DATA_FIRST)) begin
            state_d = ST_DATA;
         end else if (cell_d == CELL_W'(CELL_CTL_FIRST)) begin
            state_d = ST_CTL;
         end else if (cell_d == '0) begin
            state_d = ST_PRE;
         end
      end
   end

   // State and registered outputs; reset restarts the stream at subframe 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= '0;
         cell_q  <= '0;
         sf_q    <= '0;
         state_q <= ST_PRE;
         pk_q    <= PK_B;
         shift_q <= '0;
         sig_q   <= 1'b0;
         ack_q   <= 1'b0;
         lr_q    <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         div_q   <= div_d;
         cell_q  <= cell_d;
         sf_q    <= sf_d;
         state_q <= state_d;
         pk_q    <= pk_d;
         shift_q <= shift_d;
         sig_q   <= sig_d;
         ack_q   <= ack_d;
         lr_q    <= lr_d;
         und_q   <= und_d;
      end
   end

   assign ack_o      = ack_q;
   assign lr_o       = lr_q;
   assign underrun_o = und_q;
   assign signal_o   = sig_q;

endmodule

// File: tb/tb_spdif_tx.sv
// Self-checking bench for spdif_tx. dut_a runs default parameters for the
// handshake, table, underrun, random and mid-subframe reset cases; dut_b runs
// with two clocks per cell to reach the block wrap at subframe 384 quickly.
module tb_spdif_tx;

   localparam int CPC_A    = 4;
   localparam int CPC_B    = 2;
   localparam int SF_COUNT = 2 * 192;
   localparam int NT       = 8;
   localparam int NR       = 6;
   localparam int NLOOP    = 390;

   typedef struct {
      logic [23:0] d;
      bit          v;
      logic        lr;
      logic        und;
      int          kind;
      logic [3:0]  vucp_off;
      logic [3:0]  vucp_on;
   } vec_t;

   typedef struct {
      logic [63:0] cells;
      bit          prev;
      logic        lr;
      logic        und;
   } frame_t;

   typedef struct {
      int idx;
      int kind;
   } kchk_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_a = 1'b0, rst_b = 1'b0;
   logic [23:0] data_a = '0, data_b = '0;
   logic        valid_a = 1'b0, valid_b = 1'b0;
   logic        ack_a, lr_a, und_a, sig_a;
   logic        ack_b, lr_b, und_b, sig_b;

   spdif_tx dut_a (
      .clk        (clk),
      .rst_n      (rst_a),
      .data_i     (data_a),
      .valid_i    (valid_a),
      .ack_o      (ack_a),
      .lr_o       (lr_a),
      .underrun_o (und_a),
      .signal_o   (sig_a)
   );

   spdif_tx #(.CLK_PER_CELL(CPC_B), .FRAMES_PER_BLOCK(192)) dut_b (
      .clk        (clk),
      .rst_n      (rst_b),
      .data_i     (data_b),
      .valid_i    (valid_b),
      .ack_o      (ack_b),
      .lr_o       (lr_b),
      .underrun_o (und_b),
      .signal_o   (sig_b)
   );

   int          n_cmp = 0;
   int          n_bad = 0;

   // reference-model state per instance
   bit          m_prev[2];
   int          m_sf[2];
   logic [23:0] m_pd[2];
   bit          m_pv[2];
   int          last_ack[2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, exp);
      end
   endtask

   function automatic int cpc_of(input int inst);
      return (inst != 0) ? CPC_B : CPC_A;
   endfunction
   function automatic logic ack_of(input int inst);
      return (inst != 0) ? ack_b : ack_a;
   endfunction
   function automatic logic lr_of(input int inst);
      return (inst != 0) ? lr_b : lr_a;
   endfunction
   function automatic logic und_of(input int inst);
      return (inst != 0) ? und_b : und_a;
   endfunction
   function automatic logic sig_of(input int inst);
      return (inst != 0) ? sig_b : sig_a;
   endfunction

   task automatic set_in(input int inst, input logic [23:0] d, input bit v);
      if (inst != 0) begin
         data_b  = d;
         valid_b = v;
      end else begin
         data_a  = d;
         valid_a = v;
      end
   endtask

   task automatic reset_model(input int inst, input logic [23:0] d, input bit v);
      m_prev[inst]   = 1'b0;
      m_sf[inst]     = 0;
      m_pd[inst]     = d;
      m_pv[inst]     = v;
      last_ack[inst] = -1;
      set_in(inst, d, v);
   endtask

   // Whole subframe as 64 cell levels (cell 0 in bit 63), built from the
   // preamble table, the previous line level and BMC of data+VUCP.
   function automatic logic [63:0] model_frame(input bit prev, input int sf, input logic [23:0] d);
      logic [7:0]  pat;
      logic [27:0] word;
      logic [63:0] f;
      bit          lvl;
      if (sf == 0)          pat = 8'b0001_0111;
      else if (sf % 2 == 1) pat = 8'b0001_1011;
      else                  pat = 8'b0001_1101;
      if (!prev) pat = ~pat;
      f         = '0;
      f[63:56]  = pat;
      lvl       = pat[0];
`ifdef SPDIF_TX_PARITY_EN
      word = {d, 3'b000, ^d};
`else
      word = {d, 4'hF};
`endif
      for (int i = 0; i < 28; i++) begin
         lvl           = ~lvl;
         f[55 - 2*i]   = lvl;
         if (word[27 - i]) lvl = ~lvl;
         f[54 - 2*i]   = lvl;
      end
      return f;
   endfunction

   function automatic logic [23:0] dec_data(input logic [63:0] f);
      logic [23:0] d;
      for (int i = 0; i < 24; i++) d[23 - i] = f[55 - 2*i] ^ f[54 - 2*i];
      return d;
   endfunction

   function automatic logic [3:0] dec_vucp(input logic [63:0] f);
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[3 - i] = f[7 - 2*i] ^ f[6 - 2*i];
      return v;
   endfunction

   // 0 = B, 1 = M, 2 = W, 3 = not a preamble
   function automatic int dec_kind(input logic [63:0] f, input bit prev);
      logic [7:0] p;
      p = prev ? f[63:56] : ~f[63:56];
      if (p == 8'b0001_0111) return 0;
      if (p == 8'b0001_1101) return 1;
      if (p == 8'b0001_1011) return 2;
      return 3;
   endfunction

   // Wait for the next ack, check handshake, hand over the next sample and
   // capture all 64 cells mid-cell; compare against the model.
   task automatic run_subframe(input int inst, input logic [23:0] nd, input bit nv, output frame_t r);
      int          c;
      bit          got;
      logic [63:0] exp;
      logic [23:0] payload;
      c       = cpc_of(inst);
      got     = 1'b0;
      r.cells = '0;
      r.prev  = m_prev[inst];
      r.lr    = 1'b0;
      r.und   = 1'b0;
      for (int w = 0; w < 64*c + 4; w++) begin
         @(negedge clk);
         if (ack_of(inst) === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ack_timeout inst%0d: got no ack in %0d cycles, required one", inst, 64*c + 4);
         return;
      end
      r.lr  = lr_of(inst);
      r.und = und_of(inst);
      if (last_ack[inst] >= 0) check("ack_period", 64'(cyc - last_ack[inst]), 64'(64 * c));
      last_ack[inst] = cyc;
      check("lr_model", r.lr, 64'(m_sf[inst] % 2));
      check("underrun_model", r.und, !m_pv[inst]);
      payload = m_pv[inst] ? m_pd[inst] : 24'h0;
      exp     = model_frame(m_prev[inst], m_sf[inst], payload);
      set_in(inst, nd, nv);
      m_pd[inst] = nd;
      m_pv[inst] = nv;
      for (int k = 0; k < 64; k++) begin
         repeat ((k == 0) ? 1 : c) @(negedge clk);
         if (k == 0) check("ack_pulse", {ack_of(inst), und_of(inst)}, 2'b00);
         r.cells[63 - k] = sig_of(inst);
      end
      check("frame_cells", r.cells, exp);
      m_prev[inst] = exp[0];
      m_sf[inst]   = (m_sf[inst] + 1) % SF_COUNT;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[NT];
      kchk_t       kchk[5];
      logic [23:0] rnd_d[NR];
      bit          rnd_v[NR];
      frame_t      r;
      logic [23:0] nd;
      bit          nv;
      int          rel, first_ack, p0, p1;
      bit          got;

      //          data        v     lr    und   kind vucp(off) vucp(on)
      tbl[0] = '{24'hdeadff, 1'b1, 1'b0, 1'b0, 0,   4'hF,     4'h1};
      tbl[1] = '{24'h123456, 1'b1, 1'b1, 1'b0, 2,   4'hF,     4'h1};
      tbl[2] = '{24'habcdef, 1'b0, 1'b0, 1'b1, 1,   4'hF,     4'h0};
      tbl[3] = '{24'h000001, 1'b1, 1'b1, 1'b0, 2,   4'hF,     4'h1};
      tbl[4] = '{24'h000003, 1'b1, 1'b0, 1'b0, 1,   4'hF,     4'h0};
      tbl[5] = '{24'hffffff, 1'b1, 1'b1, 1'b0, 2,   4'hF,     4'h0};
      tbl[6] = '{24'h000000, 1'b1, 1'b0, 1'b0, 1,   4'hF,     4'h0};
      tbl[7] = '{24'h800000, 1'b1, 1'b1, 1'b0, 2,   4'hF,     4'h1};

      kchk[0] = '{0,   0};
      kchk[1] = '{1,   2};
      kchk[2] = '{2,   1};
      kchk[3] = '{383, 2};
      kchk[4] = '{384, 0};

      for (int j = 0; j < NR; j++) begin
         rnd_d[j] = 24'($urandom);
         rnd_v[j] = ($urandom_range(0, 3) != 0);
      end

      set_in(1, 24'h0, 1'b0);
      reset_model(0, tbl[0].d, tbl[0].v);
      first_ack = 0;

      // reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_hold", {sig_a, ack_a, und_a, lr_a}, 4'b0000);
      end
      rst_a = 1'b1;
      rel   = cyc;

      // table-driven subframes
      for (int i = 0; i < NT; i++) begin
         nd = (i + 1 < NT) ? tbl[i + 1].d : rnd_d[0];
         nv = (i + 1 < NT) ? tbl[i + 1].v : rnd_v[0];
         run_subframe(0, nd, nv, r);
         if (i == 0) begin
            check("first_ack_latency", 64'(last_ack[0] - rel), 64'd1);
            check("first_preamble", r.cells[63:56], 8'b1110_1000);
            first_ack = last_ack[0];
         end
         if (i == 1) check("second_ack_gap", 64'(last_ack[0] - first_ack), 64'd256);
         check("tbl_lr", r.lr, tbl[i].lr);
         check("tbl_underrun", r.und, tbl[i].und);
         check("tbl_kind", 64'(dec_kind(r.cells, r.prev)), 64'(tbl[i].kind));
         check("tbl_data", dec_data(r.cells), tbl[i].v ? tbl[i].d : 24'h0);
`ifdef SPDIF_TX_PARITY_EN
         check("tbl_vucp", dec_vucp(r.cells), tbl[i].vucp_on);
`else
         check("tbl_vucp", dec_vucp(r.cells), tbl[i].vucp_off);
`endif
      end

      // random samples with occasional underruns
      for (int j = 0; j < NR; j++) begin
         nd = (j + 1 < NR) ? rnd_d[j + 1] : 24'h55aa33;
         nv = (j + 1 < NR) ? rnd_v[j + 1] : 1'b1;
         run_subframe(0, nd, nv, r);
         check("rand_data", dec_data(r.cells), rnd_v[j] ? rnd_d[j] : 24'h0);
      end

      // reset in the middle of a subframe, around cell 30, while the line is high
      got = 1'b0;
      for (int w = 0; w < 64*CPC_A + 4; w++) begin
         @(negedge clk);
         if (ack_a === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL midreset_ack_timeout: got no ack, required one");
      end
      repeat (1 + 30*CPC_A) @(negedge clk);
      for (int w = 0; w < 16; w++) begin
         if (sig_a === 1'b1) break;
         @(negedge clk);
      end
      #2 rst_a = 1'b0;
      #1 check("async_reset", {sig_a, ack_a, und_a, lr_a}, 4'b0000);
      repeat (2) @(negedge clk);
      reset_model(0, 24'h0f0f0f, 1'b1);
      rst_a = 1'b1;
      rel   = cyc;
      run_subframe(0, 24'h123abc, 1'b1, r);
      check("restart_latency", 64'(last_ack[0] - rel), 64'd1);
      check("restart_B", r.cells[63:56], 8'b1110_1000);
      check("restart_lr", r.lr, 1'b0);
      check("restart_data", dec_data(r.cells), 24'h0f0f0f);
      run_subframe(0, 24'h0, 1'b1, r);
      check("restart_next_W", 64'(dec_kind(r.cells, r.prev)), 64'd2);

      // long incrementing stream through the block wrap on dut_b
      rst_a = 1'b0;
      reset_model(1, 24'h0, 1'b1);
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      p0 = 0;
      p1 = 0;
      for (int n = 0; n < NLOOP; n++) begin
         run_subframe(1, 24'(n + 1), 1'b1, r);
         check("loop_data", dec_data(r.cells), 24'(n));
         if (r.prev) p1++;
         else        p0++;
         for (int k = 0; k < 5; k++) begin
            if (kchk[k].idx == n)
               check("block_kind", 64'(dec_kind(r.cells, r.prev)), 64'(kchk[k].kind));
         end
      end
      check("both_polarities", {p0 > 0, p1 > 0}, 2'b11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
